// File: rtl/fht_io_ctrl.sv
// FHT I/O controller: loads a frame into 4 interleaved RAM banks, starts the core, then streams results.
// Optional watchdog on the core handshake is enabled by defining FHT_IO_TIMEOUT_EN.
module fht_io_ctrl #(
  parameter int D_BIT       = 17,
  parameter int A_BIT       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-2:0] iIN_DATA,
  input  logic             iIN_VALID,
  output logic             oIN_READY,
  output logic [D_BIT-2:0] oDATA_WR,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iRDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic             oOUT_LAST,
  output logic             oDONE,
  output logic             oERR
);

  typedef enum logic [2:0] {LOAD, START, WAIT_LO, WAIT_HI, RD, CAP, OUT} state_t;

  localparam logic [A_BIT-1:0] A_MAX = '1;

  state_t           state;
  logic [A_BIT+1:0] n;
  logic [1:0]       j;
  logic [D_BIT-1:0] hold [4];

`ifdef FHT_IO_TIMEOUT_EN
  localparam int          CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign oERR = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= LOAD;
      n          <= '0;
      j          <= '0;
      oIN_READY  <= 1'b1;
      oDATA_WR   <= '0;
      oADDR_WR   <= '0;
      oWE        <= '0;
      oSTART     <= 1'b0;
      oADDR_RD   <= '0;
      oOUT_DATA  <= '0;
      oOUT_VALID <= 1'b0;
      oOUT_LAST  <= 1'b0;
      oDONE      <= 1'b0;
`ifdef FHT_IO_TIMEOUT_EN
      oERR       <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      oDONE  <= 1'b0;
      case (state)
        LOAD: begin
          if (iIN_VALID) begin
            oWE      <= 4'b0001 << n[1:0];
            oADDR_WR <= n[A_BIT+1:2];
            oDATA_WR <= iIN_DATA;
            n        <= n + 1'b1;
            if (n == '1) begin
              state     <= START;
              oIN_READY <= 1'b0;
            end
          end
        end
        START: begin
          oSTART <= 1'b1;
          state  <= WAIT_LO;
`ifdef FHT_IO_TIMEOUT_EN
          oERR   <= 1'b0;
          cnt    <= '0;
`endif
        end
        WAIT_LO: if (!iRDY) state <= WAIT_HI;
        WAIT_HI: begin
          if (iRDY) begin
            state    <= RD;
            oADDR_RD <= '0;
          end
        end
        RD: state <= CAP;
        CAP: begin
          hold[0]    <= iDATA_0;
          hold[1]    <= iDATA_1;
          hold[2]    <= iDATA_2;
          hold[3]    <= iDATA_3;
          oOUT_DATA  <= iDATA_0;
          oOUT_VALID <= 1'b1;
          oOUT_LAST  <= 1'b0;
          j          <= '0;
          state      <= OUT;
        end
        OUT: begin
          if (iOUT_READY) begin
            if (j != 2'd3) begin
              j         <= j + 2'd1;
              oOUT_DATA <= hold[j + 2'd1];
              // last word of the frame is bank 3 of the top address
              oOUT_LAST <= (j == 2'd2) && (oADDR_RD == A_MAX);
            end else begin
              oOUT_VALID <= 1'b0;
              oOUT_LAST  <= 1'b0;
              j          <= '0;
              if (oADDR_RD != A_MAX) begin
                oADDR_RD <= oADDR_RD + 1'b1;
                state    <= RD;
              end else begin
                oDONE     <= 1'b1;
                oIN_READY <= 1'b1;
                n         <= '0;
                state     <= LOAD;
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
`ifdef FHT_IO_TIMEOUT_EN
      // placed after the case so an expiry overrides any wait-state transition
      if (state == WAIT_LO || state == WAIT_HI) begin
        cnt <= cnt + 1'b1;
        if (cnt == TMAX) begin
          oERR      <= 1'b1;
          oIN_READY <= 1'b1;
          n         <= '0;
          state     <= LOAD;
        end
      end
`endif
    end
  end

endmodule
